// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and datapath width.
package y86_pkg;

  localparam int unsigned DATA_W = 64;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t REG_RSP  = 4'h4;
  localparam reg_id_t REG_NONE = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x DATA_W storage, two async read ports, E/M write ports
// with M taking priority when both target the same register.
module y86_regfile
  import y86_pkg::reg_id_t, y86_pkg::REG_NONE, y86_pkg::REG_RSP;
#(
  parameter int unsigned        DATA_W   = 64,
  parameter int unsigned        NREGS    = 15,
  parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_id_t           src_a,
  input  reg_id_t           src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic              wr_en,
  input  reg_id_t           dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  reg_id_t           dst_m,
  input  logic [DATA_W-1:0] val_m
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next state: E write first, then M so a shared destination keeps valM.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      if (dst_e != REG_NONE) regs_d[dst_e] = val_e;
      if (dst_m != REG_NONE) regs_d[dst_m] = val_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (32'(i) == 32'(REG_RSP)) ? RSP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // IDs at or above NREGS (only F in practice) read as zero.
  always_comb begin
    val_a = '0;
    val_b = '0;
    if (32'(src_a) < NREGS) val_a = regs_q[src_a];
    if (32'(src_b) < NREGS) val_b = regs_q[src_b];
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back stage: decodes register IDs, reads operands and commits
// results. Define DWB_BYPASS_EN to forward same-cycle write data onto valA/valB.
module decode_writeback
  import y86_pkg::reg_id_t, y86_pkg::REG_NONE, y86_pkg::REG_RSP;
#(
  parameter int unsigned        DATA_W   = 64,
  parameter logic [DATA_W-1:0]  RSP_INIT = '0,
  parameter int unsigned        NREGS    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  reg_id_t           rA,
  input  reg_id_t           rB,
  input  logic              instr_valid,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              wb_en,
  output reg_id_t           srcA,
  output reg_id_t           srcB,
  output reg_id_t           dstE,
  output reg_id_t           dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              halted
);

  logic              halted_q, halted_d;
  logic [DATA_W-1:0] rf_val_a, rf_val_b;
  logic              ifun_unused;

  assign ifun_unused = ^ifun;

  // Register-ID decode; invalid or out-of-range instructions name no registers.
  always_comb begin
    srcA = REG_NONE;
    srcB = REG_NONE;
    dstE = REG_NONE;
    dstM = REG_NONE;
    if (instr_valid && icode <= y86_pkg::I_POPQ) begin
      case (icode)
        y86_pkg::I_RRMOVQ: begin
          srcA = rA;
          if (cnd) dstE = rB;
        end
        y86_pkg::I_IRMOVQ: dstE = rB;
        y86_pkg::I_RMMOVQ: begin
          srcA = rA;
          srcB = rB;
        end
        y86_pkg::I_MRMOVQ: begin
          srcB = rB;
          dstM = rA;
        end
        y86_pkg::I_OPQ: begin
          srcA = rA;
          srcB = rB;
          dstE = rB;
        end
        y86_pkg::I_CALL: begin
          srcB = REG_RSP;
          dstE = REG_RSP;
        end
        y86_pkg::I_RET: begin
          srcA = REG_RSP;
          srcB = REG_RSP;
          dstE = REG_RSP;
        end
        y86_pkg::I_PUSHQ: begin
          srcA = rA;
          srcB = REG_RSP;
          dstE = REG_RSP;
        end
        y86_pkg::I_POPQ: begin
          srcA = REG_RSP;
          srcB = REG_RSP;
          dstE = REG_RSP;
          dstM = rA;
        end
        default: ;
      endcase
    end
  end

  y86_regfile #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .src_a (srcA),
    .src_b (srcB),
    .val_a (rf_val_a),
    .val_b (rf_val_b),
    .wr_en (wb_en && !halted_q),
    .dst_e (dstE),
    .val_e (valE),
    .dst_m (dstM),
    .val_m (valM)
  );

`ifdef DWB_BYPASS_EN
  // Forward pending write data; valM overrides valE overrides stored value.
  always_comb begin
    valA = rf_val_a;
    valB = rf_val_b;
    if (wb_en) begin
      if (srcA != REG_NONE && srcA == dstE) valA = valE;
      if (srcA != REG_NONE && srcA == dstM) valA = valM;
      if (srcB != REG_NONE && srcB == dstE) valB = valE;
      if (srcB != REG_NONE && srcB == dstM) valB = valM;
    end
  end
`else
  assign valA = rf_val_a;
  assign valB = rf_val_b;
`endif

  always_comb begin
    halted_d = halted_q;
    if (wb_en && icode == y86_pkg::I_HALT) halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  assign halted = halted_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed test-plan cases plus random
// instruction streams compared against a behavioural register-file model.
module tb_decode_writeback;

  localparam logic [63:0] RSP = 64'h100;
  localparam logic [3:0]  F   = 4'hF;

  logic        clk = 1'b0;
  logic        rst, instr_valid, cnd, wb_en;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;
  logic        halted;

  decode_writeback #(.DATA_W(64), .RSP_INIT(RSP), .NREGS(15)) dut (
    .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .instr_valid(instr_valid), .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural model.
  logic [63:0] m_reg [15];
  logic        m_halt;
  logic        m_valid = 1'b0;

  // Values sampled from the DUT just before the most recent commit edge.
  logic [3:0]  s_srcA, s_dstE;
  logic [63:0] s_valA, s_valB;
  logic        s_halted;

  function automatic logic live(input logic [3:0] ic, input logic v);
    return v && ic <= 4'hB;
  endfunction

  function automatic logic [3:0] e_srcA(input logic [3:0] ic, ra, input logic v);
    if (!live(ic, v)) return F;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] e_srcB(input logic [3:0] ic, rb, input logic v);
    if (!live(ic, v)) return F;
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] e_dstE(input logic [3:0] ic, rb, input logic v, c);
    if (!live(ic, v)) return F;
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return c ? rb : F;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] e_dstM(input logic [3:0] ic, ra, input logic v);
    if (!live(ic, v)) return F;
    if (ic inside {4'h5, 4'hB}) return ra;
    return F;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] id);
    return (id == F) ? 64'd0 : m_reg[id];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One instruction cycle: drive, check combinational outputs, commit, update model.
  task automatic cycle(input logic r, input logic [3:0] ic, ra, rb, input logic v, c,
                       input logic [63:0] ve, vm, input logic we);
    logic [3:0]  xa, xb, xe, xm;
    logic [63:0] va, vb;
    rst = r; icode = ic; ifun = 4'($urandom_range(0, 15)); rA = ra; rB = rb;
    instr_valid = v; cnd = c; valE = ve; valM = vm; wb_en = we;
    #3;
    xa = e_srcA(ic, ra, v);
    xb = e_srcB(ic, rb, v);
    xe = e_dstE(ic, rb, v, c);
    xm = e_dstM(ic, ra, v);
    va = m_read(xa);
    vb = m_read(xb);
`ifdef DWB_BYPASS_EN
    if (we && xa != F && xa == xe) va = ve;
    if (we && xa != F && xa == xm) va = vm;
    if (we && xb != F && xb == xe) vb = ve;
    if (we && xb != F && xb == xm) vb = vm;
`endif
    s_srcA = srcA; s_dstE = dstE; s_valA = valA; s_valB = valB; s_halted = halted;
    chk("srcA", 64'(srcA), 64'(xa));
    chk("srcB", 64'(srcB), 64'(xb));
    chk("dstE", 64'(dstE), 64'(xe));
    chk("dstM", 64'(dstM), 64'(xm));
    if (m_valid) begin
      chk("valA", valA, va);
      chk("valB", valB, vb);
      chk("halted", 64'(halted), 64'(m_halt));
    end
    @(posedge clk);
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = (i == 4) ? RSP : 64'd0;
      m_halt  = 1'b0;
      m_valid = 1'b1;
    end else if (we && !m_halt) begin
      if (xe != F) m_reg[xe] = ve;
      if (xm != F) m_reg[xm] = vm;
      if (ic == 4'h0) m_halt = 1'b1;
    end
    #1;
  endtask

  initial begin
    // Reset, then read %rsp and reg 0 via pushq.
    cycle(1, 4'h1, F, F, 1, 0, 0, 0, 0);
    cycle(0, 4'hA, 4'h0, F, 1, 0, 0, 0, 0);
    chk("t1_valB_rsp", s_valB, 64'h100);
    chk("t1_valA_r0", s_valA, 64'h0);

    // irmovq then OPq readback.
    cycle(0, 4'h3, F, 4'h2, 1, 0, 64'h1234, 0, 1);
    cycle(0, 4'h6, 4'h2, 4'h2, 1, 0, 0, 0, 0);
    chk("t2_valA", s_valA, 64'h1234);
    chk("t2_valB", s_valB, 64'h1234);

    // cmov not taken, then taken.
    cycle(0, 4'h2, 4'h1, 4'h3, 1, 0, 64'd5, 0, 1);
    chk("t3_dstE_nt", 64'(s_dstE), 64'hF);
    cycle(0, 4'h6, 4'h3, 4'h3, 1, 0, 0, 0, 0);
    chk("t3_r3_nt", s_valA, 64'h0);
    cycle(0, 4'h2, 4'h1, 4'h3, 1, 1, 64'd5, 0, 1);
    chk("t3_dstE_t", 64'(s_dstE), 64'h3);
    cycle(0, 4'h6, 4'h3, 4'h3, 1, 0, 0, 0, 0);
    chk("t3_r3_t", s_valA, 64'd5);

    // popq %rsp: valM wins.
    cycle(0, 4'hB, 4'h4, F, 1, 0, 64'h108, 64'hAA, 1);
    cycle(0, 4'hA, 4'h4, F, 1, 0, 0, 0, 0);
    chk("t4_rsp", s_valA, 64'hAA);

    // halt blocks writes until reset.
    cycle(0, 4'h0, F, F, 1, 0, 0, 0, 1);
    cycle(0, 4'h3, F, 4'h5, 1, 0, 64'd7, 0, 1);
    chk("t5_halted", 64'(s_halted), 64'h1);
    cycle(0, 4'h6, 4'h5, 4'h5, 1, 0, 0, 0, 0);
    chk("t5_r5", s_valA, 64'h0);
    cycle(1, 4'h1, F, F, 1, 0, 0, 0, 0);
    cycle(0, 4'h6, 4'h2, 4'h2, 1, 0, 0, 0, 0);
    chk("t5_unhalt", 64'(s_halted), 64'h0);
    chk("t5_r2_clr", s_valA, 64'h0);

    // Invalid icode, invalid instr, write to F.
    cycle(0, 4'hC, 4'h1, 4'h2, 1, 0, 64'd9, 64'd9, 1);
    chk("t6_srcA_F", 64'(s_srcA), 64'hF);
    chk("t6_dstE_F", 64'(s_dstE), 64'hF);
    cycle(0, 4'h3, F, 4'h1, 0, 0, 64'd9, 0, 1);
    cycle(0, 4'h3, F, F, 1, 0, 64'd9, 0, 1);
    cycle(0, 4'h6, 4'h1, F, 1, 0, 0, 0, 0);
    chk("t6_r1", s_valA, 64'h0);
    chk("t6_readF", s_valB, 64'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ic, ra, rb;
      ic = ($urandom_range(0, 29) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ra = ($urandom_range(0, 4) == 0) ? F : 4'($urandom_range(0, 14));
      rb = ($urandom_range(0, 4) == 0) ? F : 4'($urandom_range(0, 14));
      cycle(($urandom_range(0, 39) == 0), ic, ra, rb, ($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
